fetch_redirect: RTL and testbench
=================================

# fetch_redirect

Fetch-side PC sequencer that sits between the instruction memory and dispatch and drives the branch unit's `inst`/`addr` inputs. It is the consumer of the branch unit's `targetAddr`. The block:
- streams sequential fetch addresses;
- detects control-transfer instructions and issues the architectural delay slot;
- holds fetch until the branch operands' reservation tags clear;
- loads the resolved target into the PC.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset.
- `flush`  in  1  external redirect (exception/restart); overrides normal flow.
- `flushAddr`  in  32  PC loaded when `flush`=1.
- `imemData`  in  32  instruction word at `pc`.
- `imemValid`  in  1  `imemData` valid this cycle.
- `stall`  in  1  dispatch cannot accept an instruction this cycle.
- `Qj`, `Qk`  in  5  reservation tags of held branch's rs/rt (0 = ready); same nets feeding the branch unit.
- `targetAddr`  in  32  resolved next PC from the branch unit.
- `pc`  out  32  current fetch address.
- `fetchReq`  out  1  instruction fetch requested (state RUN or SLOT).
- `issueValid`  out  1  registered; one-cycle pulse per accepted instruction.
- `issueInst`, `issueAddr`  out  32  registered instruction and its address.
- `brInst`, `brAddr`  out  32  held control instruction and its address, to branch unit `inst`/`addr`.
- `redirect`  out  1  registered one-cycle pulse: PC was loaded from `targetAddr`.
- `jrstall`  out  1  combinational: state WAIT and `Qj`≠0.

## Operation
- **Control-instruction decode** (on `imemData`): opcode 2 (j), 3 (jal), 4 (beq), 5 (bne); opcode 1 with rt=0 (bltz) or rt=1 (bgez); opcode 0 with funct 8 (jr). Opcode 1 with any other rt is not control.
- **Accept** = `fetchReq` & `imemValid` & !`stall`. On accept: `issueInst`←`imemData`, `issueAddr`←`pc`, `issueValid`←1. Otherwise `issueValid`←0.
- **States:** RUN, SLOT, WAIT (2-bit encoding).
- **RUN**
  - Accept of a non-control instruction: `pc`←`pc`+4.
  - Accept of a control instruction: `brInst`←`imemData`, `brAddr`←`pc`, `pc`←`pc`+4, go to SLOT.
- **SLOT**
  - On accept, issue the delay-slot instruction (issued even if it decodes as control; it is not captured), then go to WAIT. `pc` is unchanged.
- **WAIT**
  - `fetchReq`=0.
  - Ready = (`Qj`==0) & (`brInst` is j/jal/jr, or `Qk`==0).
  - When ready: `pc`←`targetAddr`, `redirect`←1, go to RUN.
  - Otherwise hold.
- `brInst`/`brAddr` stay stable from capture until the next control capture.
- `pc` arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- **Priority:** `reset` > `flush` > normal.
  - `flush` from any state: `pc`←`flushAddr`, state←RUN, `issueValid`←0, `redirect`←0. `brInst`/`brAddr` unchanged.
- **Reset values:** `pc`=`RESET_VECTOR`, state=RUN, `issueValid`=0, `issueInst`=0, `issueAddr`=0, `brInst`=0, `brAddr`=0, `redirect`=0. `jrstall`=0 follows from state RUN.
- `stall` in WAIT has no effect. `imemValid`=0 in RUN/SLOT holds state and `pc`.

## Timing
- Accept in cycle n → `issueValid`=1 in n+1.
- **Fastest branch sequence:** branch accepted at n, slot at n+1, WAIT at n+2 (ready), `pc`=target and `redirect`=1 at n+3, target instruction issued at n+4.
- Each cycle WAIT sees not-ready adds one cycle. `targetAddr` is sampled only at the WAIT→RUN edge.
- `flush` asserted in cycle n → `pc`=`flushAddr` in n+1. An accept in cycle n is discarded.
- A reset mid-WAIT abandons the branch. No `redirect` is produced.

## Test plan
- **Reset then streaming:** reset, feed nops with `imemValid`=1 → `pc`=0,4,8,… each cycle; `issueAddr` lags by one cycle; `issueValid` continuous.
- **beq at 0x100 with `Qj`=`Qk`=0, `targetAddr`=0x200:**
  - Issues 0x100 then 0x104.
  - `pc`=0x200 with `redirect`=1 three cycles after the branch accept.
  - `fetchReq`=0 for exactly one cycle.
- **jr at 0x40 with `Qj`=5 for 4 cycles, then 0:**
  - `jrstall`=1 for 4 cycles, `Qk`=7 ignored.
  - Then `pc`=`targetAddr` (0x80).
- **bne with `Qj`=0 and `Qk`=3 for 2 cycles:** remains in WAIT; `jrstall`=0; redirect once `Qk`=0.
- **Stall/imemValid gaps:** `stall`=1 for 3 cycles during SLOT → delay slot issued only after release; `pc` held at branch+4.
- **Flush during WAIT (`flushAddr`=0x8000_0180):** next cycle `pc`=0x8000_0180, state RUN, no `redirect`. Also check 32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/fetch_redirect.sv
// Fetch-side PC sequencer: sequential fetch, delay-slot issue, hold on branch operand tags, redirect to target.
// Latency: accept in cycle n -> issueValid in n+1; fastest branch -> pc=target/redirect at accept+3.
// Backpressure: stall or !imemValid holds pc and state in RUN/SLOT; WAIT ignores stall and waits on Qj/Qk.
//
// Ports:
//   clk, reset (sync, active-high), flush/flushAddr (external redirect, beats normal flow)
//   imemData/imemValid  : instruction word at pc and its valid
//   stall               : dispatch cannot take an instruction this cycle
//   Qj, Qk              : reservation tags of the held branch's rs/rt (0 = ready)
//   targetAddr          : resolved next PC from the branch unit
//   pc, fetchReq        : current fetch address and fetch request (RUN or SLOT)
//   issueValid/Inst/Addr: registered one-cycle issue of each accepted instruction
//   brInst, brAddr      : held control instruction and its address for the branch unit
//   redirect            : one-cycle pulse when pc was loaded from targetAddr
//   jrstall             : WAIT state with rs tag still pending
module fetch_redirect #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flushAddr,
   input  logic [31:0] imemData,
   input  logic        imemValid,
   input  logic        stall,
   input  logic [4:0]  Qj,
   input  logic [4:0]  Qk,
   input  logic [31:0] targetAddr,
   output logic [31:0] pc,
   output logic        fetchReq,
   output logic        issueValid,
   output logic [31:0] issueInst,
   output logic [31:0] issueAddr,
   output logic [31:0] brInst,
   output logic [31:0] brAddr,
   output logic        redirect,
   output logic        jrstall
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_SLOT = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0] state;
   logic       accept;
   logic       is_ctrl;
   logic       br_uncond;
   logic       br_ready;

   // Decode of the incoming word: j/jal/beq/bne, bltz/bgez (REGIMM rt 0/1), jr.
   always_comb begin
      is_ctrl = 1'b0;
      case (imemData[31:26])
         6'd2, 6'd3, 6'd4, 6'd5: is_ctrl = 1'b1;
         6'd1:                   is_ctrl = (imemData[20:16] == 5'd0) || (imemData[20:16] == 5'd1);
         6'd0:                   is_ctrl = (imemData[5:0] == 6'd8);
         default:                is_ctrl = 1'b0;
      endcase
   end

   // j/jal/jr have no rt operand, so the rt tag must not hold them.
   always_comb begin
      br_uncond = 1'b0;
      case (brInst[31:26])
         6'd2, 6'd3: br_uncond = 1'b1;
         6'd0:       br_uncond = (brInst[5:0] == 6'd8);
         default:    br_uncond = 1'b0;
      endcase
   end

   assign br_ready = (Qj == 5'd0) && (br_uncond || (Qk == 5'd0));
   assign fetchReq = (state == ST_RUN) || (state == ST_SLOT);
   assign accept   = fetchReq && imemValid && !stall;
   assign jrstall  = (state == ST_WAIT) && (Qj != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_VECTOR;
         state      <= ST_RUN;
         issueValid <= 1'b0;
         issueInst  <= 32'd0;
         issueAddr  <= 32'd0;
         brInst     <= 32'd0;
         brAddr     <= 32'd0;
         redirect   <= 1'b0;
      end else if (flush) begin
         // Any accept in this cycle is dropped; the held branch is left untouched.
         pc         <= flushAddr;
         state      <= ST_RUN;
         issueValid <= 1'b0;
         redirect   <= 1'b0;
      end else begin
         issueValid <= accept;
         redirect   <= 1'b0;
         if (accept) begin
            issueInst <= imemData;
            issueAddr <= pc;
         end
         case (state)
            ST_RUN: begin
               if (accept) begin
                  pc <= pc + 32'd4;
                  if (is_ctrl) begin
                     brInst <= imemData;
                     brAddr <= pc;
                     state  <= ST_SLOT;
                  end
               end
            end
            ST_SLOT: begin
               // Delay slot already sits at pc; issue it without advancing.
               if (accept) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (br_ready) begin
                  pc       <= targetAddr;
                  redirect <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

   logic        clk = 1'b0;
   logic        reset, flush, imemValid, stall;
   logic [31:0] flushAddr, imemData, targetAddr;
   logic [4:0]  Qj, Qk;
   logic [31:0] pc, issueInst, issueAddr, brInst, brAddr;
   logic        fetchReq, issueValid, redirect, jrstall;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_issue[$];   // {addr, inst}
   logic [31:0] exp_redir[$];   // pc expected when redirect pulses

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] ADDI = 32'h2001_0005;
   localparam logic [31:0] RIMM = 32'h0402_0000;   // opcode 1, rt=2: not control
   localparam logic [31:0] BEQ  = 32'h1022_0010;
   localparam logic [31:0] BNE  = 32'h1443_0008;
   localparam logic [31:0] JR   = 32'h03E0_0008;
   localparam logic [31:0] BLTZ = 32'h0420_0010;
   localparam logic [31:0] JMP  = 32'h0800_0040;

   always #5 clk = ~clk;

   fetch_redirect #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .flush(flush), .flushAddr(flushAddr),
      .imemData(imemData), .imemValid(imemValid), .stall(stall),
      .Qj(Qj), .Qk(Qk), .targetAddr(targetAddr),
      .pc(pc), .fetchReq(fetchReq), .issueValid(issueValid),
      .issueInst(issueInst), .issueAddr(issueAddr),
      .brInst(brInst), .brAddr(brAddr), .redirect(redirect), .jrstall(jrstall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      imemValid = v;
      stall     = s;
      imemData  = d;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an issue or redirect.
   always @(negedge clk) begin
      if (issueValid === 1'b1) begin
         if (exp_issue.size() == 0) begin
            check("unexpected_issue", issueAddr, 32'hDEAD_DEAD);
         end else begin
            logic [63:0] e;
            e = exp_issue.pop_front();
            check("issueAddr", issueAddr, e[63:32]);
            check("issueInst", issueInst, e[31:0]);
         end
      end
      if (redirect === 1'b1) begin
         if (exp_redir.size() == 0) begin
            check("unexpected_redirect", pc, 32'hDEAD_DEAD);
         end else begin
            logic [31:0] r;
            r = exp_redir.pop_front();
            check("redirect_pc", pc, r);
         end
      end
   end

   initial begin
      logic [31:0] vec [0:5];
      vec[0] = NOP; vec[1] = ADDI; vec[2] = RIMM; vec[3] = NOP; vec[4] = ADDI; vec[5] = RIMM;

      reset = 1'b1; flush = 1'b0; flushAddr = 32'd0; targetAddr = 32'd0;
      Qj = 5'd0; Qk = 5'd0;
      drive(1'b0, 1'b0, NOP);
      step(); step();
      reset = 1'b0;

      // Reset state
      check("rst_pc", pc, 32'h0);
      check("rst_issueValid", {31'd0, issueValid}, 32'd0);
      check("rst_redirect", {31'd0, redirect}, 32'd0);
      check("rst_jrstall", {31'd0, jrstall}, 32'd0);
      check("rst_fetchReq", {31'd0, fetchReq}, 32'd1);
      check("rst_brInst", brInst, 32'd0);
      check("rst_issueInst", issueInst, 32'd0);

      // Streaming, including an opcode-1 word that is not control
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, vec[i]);
         check("stream_pc", pc, 32'(i * 4));
         exp_issue.push_back({32'(i * 4), vec[i]});
         step();
      end
      check("stream_pc_end", pc, 32'h18);

      // Flush to 0x100; the accept in the flush cycle is dropped
      flush = 1'b1; flushAddr = 32'h100; drive(1'b1, 1'b0, ADDI);
      step();
      flush = 1'b0;
      check("flush_pc", pc, 32'h100);
      check("flush_issueValid", {31'd0, issueValid}, 32'd0);

      // beq at 0x100, operands ready, target 0x200
      targetAddr = 32'h200;
      drive(1'b1, 1'b0, BEQ); exp_issue.push_back({32'h100, BEQ});
      step();
      check("beq_pc_slot", pc, 32'h104);
      check("beq_brInst", brInst, BEQ);
      check("beq_brAddr", brAddr, 32'h100);
      drive(1'b1, 1'b0, ADDI); exp_issue.push_back({32'h104, ADDI});
      step();
      check("beq_wait_fetchReq", {31'd0, fetchReq}, 32'd0);
      check("beq_wait_pc", pc, 32'h104);
      drive(1'b1, 1'b0, NOP);
      exp_redir.push_back(32'h200);
      step();
      check("beq_redirect", {31'd0, redirect}, 32'd1);
      check("beq_target_pc", pc, 32'h200);
      check("beq_fetchReq_back", {31'd0, fetchReq}, 32'd1);
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'h200, NOP});
      step();
      check("beq_redirect_pulse", {31'd0, redirect}, 32'd0);

      // jr at 0x40: Qj pending for 4 cycles, Qk=7 ignored
      flush = 1'b1; flushAddr = 32'h40; drive(1'b0, 1'b0, NOP);
      step();
      flush = 1'b0;
      Qj = 5'd5; Qk = 5'd7; targetAddr = 32'h80;
      drive(1'b1, 1'b0, JR); exp_issue.push_back({32'h40, JR});
      step();
      check("jr_slot_jrstall", {31'd0, jrstall}, 32'd0);
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'h44, NOP});
      step();
      for (int i = 0; i < 4; i++) begin
         check("jr_jrstall", {31'd0, jrstall}, 32'd1);
         check("jr_hold_pc", pc, 32'h44);
         step();
      end
      Qj = 5'd0;
      #1;
      check("jr_jrstall_clear", {31'd0, jrstall}, 32'd0);
      exp_redir.push_back(32'h80);
      step();
      check("jr_target_pc", pc, 32'h80);

      // bne at 0x80: Qk pending 2 cycles
      Qk = 5'd3; targetAddr = 32'h300;
      drive(1'b1, 1'b0, BNE); exp_issue.push_back({32'h80, BNE});
      step();
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'h84, NOP});
      step();
      for (int i = 0; i < 2; i++) begin
         check("bne_jrstall", {31'd0, jrstall}, 32'd0);
         check("bne_hold_pc", pc, 32'h84);
         step();
      end
      Qk = 5'd0; exp_redir.push_back(32'h300);
      step();
      check("bne_target_pc", pc, 32'h300);

      // bltz at 0x300, stall and imemValid gaps during SLOT; slot word is a j
      targetAddr = 32'h400;
      drive(1'b1, 1'b0, BLTZ); exp_issue.push_back({32'h300, BLTZ});
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, ADDI);
         check("slot_stall_pc", pc, 32'h304);
         check("slot_stall_fetchReq", {31'd0, fetchReq}, 32'd1);
         step();
      end
      drive(1'b0, 1'b0, ADDI);
      step();
      check("slot_novalid_pc", pc, 32'h304);
      drive(1'b1, 1'b0, JMP); exp_issue.push_back({32'h304, JMP});
      step();
      check("slot_brInst_kept", brInst, BLTZ);
      check("slot_brAddr_kept", brAddr, 32'h300);
      drive(1'b1, 1'b1, NOP);   // stall has no effect in WAIT
      exp_redir.push_back(32'h400);
      step();
      check("bltz_target_pc", pc, 32'h400);

      // beq at 0x400 held by Qj, then flushed out of WAIT
      Qj = 5'd1;
      drive(1'b1, 1'b0, BEQ); exp_issue.push_back({32'h400, BEQ});
      step();
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'h404, NOP});
      step();
      check("fw_jrstall", {31'd0, jrstall}, 32'd1);
      flush = 1'b1; flushAddr = 32'h8000_0180; drive(1'b0, 1'b0, NOP);
      step();
      flush = 1'b0;
      check("fw_pc", pc, 32'h8000_0180);
      check("fw_fetchReq", {31'd0, fetchReq}, 32'd1);
      check("fw_jrstall_clear", {31'd0, jrstall}, 32'd0);
      check("fw_redirect", {31'd0, redirect}, 32'd0);
      check("fw_brInst_kept", brInst, BEQ);
      step();
      check("fw_redirect_later", {31'd0, redirect}, 32'd0);

      // PC wrap
      flush = 1'b1; flushAddr = 32'hFFFF_FFFC;
      step();
      flush = 1'b0;
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'hFFFF_FFFC, NOP});
      step();
      check("wrap_pc", pc, 32'h0);
      drive(1'b1, 1'b0, ADDI); exp_issue.push_back({32'h0, ADDI});
      step();
      check("wrap_pc_next", pc, 32'h4);

      // j at 0x4 held by Qj, reset mid-WAIT abandons it
      Qj = 5'd3;
      drive(1'b1, 1'b0, JMP); exp_issue.push_back({32'h4, JMP});
      step();
      drive(1'b1, 1'b0, NOP); exp_issue.push_back({32'h8, NOP});
      step();
      check("rw_fetchReq", {31'd0, fetchReq}, 32'd0);
      reset = 1'b1; drive(1'b0, 1'b0, NOP);
      step();
      reset = 1'b0;
      check("rw_pc", pc, 32'h0);
      check("rw_fetchReq", {31'd0, fetchReq}, 32'd1);
      check("rw_brInst", brInst, 32'h0);
      check("rw_issueValid", {31'd0, issueValid}, 32'd0);
      step(); step();
      check("rw_redirect", {31'd0, redirect}, 32'd0);

      check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
      check("redir_queue_drained", 32'(exp_redir.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
